// File: rtl/peripheral_mult_pkg.sv
// Shared types and constants for the IEEE-754 multiplier peripheral.
// Used by the sequencer, the operand-capture block and the display mux.
package peripheral_mult_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SHOW    = 3'd4,
        ST_ERROR   = 3'd5
    } seq_state_t;

    // Slots 0-3 are A[31:24]..A[7:0]; slots 4-7 are the same byte order for B.
    localparam logic [3:0] SLOT_A0     = 4'd0;
    localparam logic [3:0] SLOT_A_LAST = 4'd3;
    localparam logic [3:0] SLOT_B0     = 4'd4;
    localparam logic [3:0] SLOT_LAST   = 4'd7;
    localparam logic [3:0] SLOT_NONE   = 4'd8;

    localparam logic [1:0] DISP_R31_24 = 2'd0;
    localparam logic [1:0] DISP_R23_16 = 2'd1;
    localparam logic [1:0] DISP_R15_8  = 2'd2;
    localparam logic [1:0] DISP_R7_0   = 2'd3;

endpackage

// File: rtl/peripheral_timeout_counter.sv
// Up-counter supervising the multiplier; expired flags the last allowed WAIT cycle.
// The count holds at its terminal value rather than wrapping.
module peripheral_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/peripheral_mult_sequencer.sv
// Sequencer for the multiplier peripheral: byte entry, launch, supervised wait,
// and paged result display.
//
// state      | meaning
// -----------+-------------------------------------------------
// ENTER_A    | capturing operand A bytes, slot 0..3
// ENTER_B    | capturing operand B bytes, slot 4..7
// START      | one-cycle multiplier launch
// WAIT       | waiting for mult_done, timeout counter running
// SHOW       | paging result bytes out via disp_sel
// ERROR      | multiplier timed out, waiting for enter
module peripheral_mult_sequencer
    import peripheral_mult_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enterpulse,
    input  logic       clearpulse,
    input  logic       mult_done,
    output logic [3:0] datainput_i,
    output logic       mult_start,
    output logic       busy,
    output logic       result_valid,
    output logic       error,
    output logic [1:0] disp_sel
);

    seq_state_t state, state_nxt;
    logic [3:0] slot, slot_nxt;
    logic [1:0] disp, disp_nxt;
    logic       tmo_clr;
    logic       tmo_expired;

    assign tmo_clr = clearpulse || (state != ST_WAIT);

    peripheral_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmo_clr),
        .en      (state == ST_WAIT),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_ENTER_A;
            slot  <= SLOT_A0;
            disp  <= DISP_R31_24;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            disp  <= disp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        disp_nxt  = disp;
        if (clearpulse) begin
            state_nxt = ST_ENTER_A;
            slot_nxt  = SLOT_A0;
            disp_nxt  = DISP_R31_24;
        end else begin
            case (state)
                ST_ENTER_A: if (enterpulse) begin
                    slot_nxt = slot + 4'd1;
                    if (slot == SLOT_A_LAST) state_nxt = ST_ENTER_B;
                end
                ST_ENTER_B: if (enterpulse) begin
                    if (slot == SLOT_LAST) begin
                        state_nxt = ST_START;
                        slot_nxt  = SLOT_A0;
                    end else begin
                        slot_nxt = slot + 4'd1;
                    end
                end
                ST_START: state_nxt = ST_WAIT;
                // done beats the timeout when both land on the same cycle
                ST_WAIT: begin
                    if (mult_done) begin
                        state_nxt = ST_SHOW;
                        disp_nxt  = DISP_R31_24;
                    end else if (tmo_expired) begin
                        state_nxt = ST_ERROR;
                    end
                end
                ST_SHOW: if (enterpulse) begin
                    if (disp == DISP_R7_0) begin
                        state_nxt = ST_ENTER_A;
                        slot_nxt  = SLOT_A0;
                        disp_nxt  = DISP_R31_24;
                    end else begin
                        disp_nxt = disp + 2'd1;
                    end
                end
                ST_ERROR: if (enterpulse) begin
                    state_nxt = ST_ENTER_A;
                    slot_nxt  = SLOT_A0;
                end
                default: begin
                    state_nxt = ST_ENTER_A;
                    slot_nxt  = SLOT_A0;
                    disp_nxt  = DISP_R31_24;
                end
            endcase
        end
    end

    always_comb begin
        datainput_i  = SLOT_NONE;
        mult_start   = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        error        = 1'b0;
        case (state)
            ST_ENTER_A, ST_ENTER_B: datainput_i = slot;
            ST_START: begin
                mult_start = 1'b1;
                busy       = 1'b1;
            end
            ST_WAIT:  busy = 1'b1;
            ST_SHOW:  result_valid = 1'b1;
            ST_ERROR: error = 1'b1;
            default:  datainput_i = SLOT_NONE;
        endcase
    end

    assign disp_sel = disp;

endmodule

// File: tb/tb_peripheral_mult_sequencer.sv
// Directed bench for peripheral_mult_sequencer with TIMEOUT_CYCLES = 8.
module tb_peripheral_mult_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enterpulse = 1'b0;
    logic       clearpulse = 1'b0;
    logic       mult_done = 1'b0;
    logic [3:0] datainput_i;
    logic       mult_start;
    logic       busy;
    logic       result_valid;
    logic       error;
    logic [1:0] disp_sel;

    int n_cmp = 0;
    int n_err = 0;
    int ms_cnt = 0;
    int ms_double = 0;
    int overlap = 0;
    int exp_launch = 0;
    logic ms_prev = 1'b0;

    peripheral_mult_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enterpulse   (enterpulse),
        .clearpulse   (clearpulse),
        .mult_done    (mult_done),
        .datainput_i  (datainput_i),
        .mult_start   (mult_start),
        .busy         (busy),
        .result_valid (result_valid),
        .error        (error),
        .disp_sel     (disp_sel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mult_start) ms_cnt++;
        if (mult_start && ms_prev) ms_double++;
        if (busy && result_valid) overlap++;
        ms_prev = mult_start;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter();
        enterpulse = 1'b1;
        tick();
        enterpulse = 1'b0;
    endtask

    // Eight back-to-back entries; returns with START visible.
    task automatic enter_all();
        for (int i = 0; i < 8; i++) pulse_enter();
        exp_launch++;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".slot"}, datainput_i, 0);
        chk({tag, ".start"}, mult_start, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".valid"}, result_valid, 0);
        chk({tag, ".error"}, error, 0);
        chk({tag, ".disp"}, disp_sel, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_idle("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // entry sweep, 3-cycle spacing
        for (int i = 0; i < 7; i++) begin
            chk("sweep.slot", datainput_i, i);
            pulse_enter();
            tick();
            tick();
        end
        chk("sweep.slot7", datainput_i, 7);
        pulse_enter();
        exp_launch++;
        chk("sweep.start", mult_start, 1);
        chk("sweep.start_busy", busy, 1);
        chk("sweep.none", datainput_i, 8);
        tick();
        chk("sweep.start_drop", mult_start, 0);
        chk("sweep.wait_busy", busy, 1);

        // done 5 cycles after the START cycle, then page out
        repeat (3) tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("done.valid", result_valid, 1);
        chk("done.busy", busy, 0);
        chk("done.disp", disp_sel, 0);
        for (int d = 1; d < 4; d++) begin
            pulse_enter();
            chk("page.disp", disp_sel, d);
            chk("page.valid", result_valid, 1);
        end
        pulse_enter();
        chk("page.ret_valid", result_valid, 0);
        chk("page.ret_slot", datainput_i, 0);

        // timeout: ERROR 8 cycles after WAIT entry
        enter_all();
        tick();
        repeat (7) tick();
        chk("tmo.pre_err", error, 0);
        chk("tmo.pre_busy", busy, 1);
        tick();
        chk("tmo.err", error, 1);
        chk("tmo.busy", busy, 0);
        chk("tmo.none", datainput_i, 8);
        pulse_enter();
        chk("tmo.recover_err", error, 0);
        chk("tmo.recover_slot", datainput_i, 0);

        // clear beats enter at slot 5
        repeat (5) pulse_enter();
        chk("clr.slot5", datainput_i, 5);
        clearpulse = 1'b1;
        enterpulse = 1'b1;
        tick();
        clearpulse = 1'b0;
        enterpulse = 1'b0;
        chk("clr.slot", datainput_i, 0);
        repeat (4) pulse_enter();
        chk("clr.reentry_b0", datainput_i, 4);
        clearpulse = 1'b1;
        tick();
        clearpulse = 1'b0;

        // done on the timeout cycle wins
        enter_all();
        tick();
        repeat (7) tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("race.valid", result_valid, 1);
        chk("race.err", error, 0);
        clearpulse = 1'b1;
        tick();
        clearpulse = 1'b0;
        chk("race.clear_valid", result_valid, 0);

        // enter ignored in WAIT, not buffered
        enter_all();
        tick();
        pulse_enter();
        chk("wenter.busy", busy, 1);
        chk("wenter.start", mult_start, 0);
        chk("wenter.none", datainput_i, 8);
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("wenter.disp", disp_sel, 0);
        chk("wenter.valid", result_valid, 1);
        clearpulse = 1'b1;
        tick();
        clearpulse = 1'b0;

        // async reset while mult_start is high
        for (int i = 0; i < 8; i++) pulse_enter();
        chk("arst.start_pre", mult_start, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.start_drop", mult_start, 0);
        chk("arst.start_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // async reset mid-WAIT
        enter_all();
        tick();
        tick();
        chk("arst.wait_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("arst.wait");
        @(negedge clk);
        reset = 1'b1;
        enter_all();
        chk("arst.new_start", mult_start, 1);
        tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("arst.new_valid", result_valid, 1);
        clearpulse = 1'b1;
        tick();
        clearpulse = 1'b0;

        // stray done in ENTER_B is ignored
        repeat (6) pulse_enter();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("stray.slot", datainput_i, 6);
        chk("stray.busy", busy, 0);
        chk("stray.valid", result_valid, 0);
        chk("stray.err", error, 0);
        chk("stray.disp", disp_sel, 0);
        pulse_enter();
        pulse_enter();
        exp_launch++;
        chk("stray.start", mult_start, 1);
        tick();
        tick();

        chk("mon.launches", ms_cnt, exp_launch);
        chk("mon.double_start", ms_double, 0);
        chk("mon.busy_valid", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/peripheral_mult_sequencer.md
# peripheral_mult_sequencer

Control FSM for the IEEE-754 multiplier peripheral. It steps the user through eight byte entries: four for operand A, four for operand B. It drives the byte-slot select used by the operand-capture block, launches the multiplier, and supervises completion with a timeout. It then pages the 32-bit result out one byte per enter pulse. It sits between the debounced button/switch front end and the operand-capture and multiplier datapath.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles before an error is declared (≥2).
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enterpulse  input  1  single-cycle, already-debounced "enter" strobe.
- clearpulse  input  1  single-cycle abort strobe. Returns the block to the start of entry from any state.
- mult_done  input  1  multiplier completion, single-cycle pulse.
- datainput_i  output  4  byte-slot select for operand capture. Values 0–3 are A[31:24], A[23:16], A[15:8], A[7:0]. Values 4–7 are the same byte order for B. Value 8 means no slot (SLOT_NONE).
- mult_start  output  1  one-cycle launch pulse to the multiplier.
- busy  output  1  high in START and WAIT.
- result_valid  output  1  high in SHOW.
- error  output  1  high in ERROR.
- disp_sel  output  2  result byte shown: 0 is R[31:24], 3 is R[7:0].

## Operation
- States: ENTER_A, ENTER_B, START, WAIT, SHOW, ERROR. Everything is registered; outputs decode from state and counters.
- ENTER_A / ENTER_B: datainput_i = current slot.
  - On enterpulse the slot increments. The capture block writes the byte for the current slot on that same edge.
  - Slot 3 + enterpulse moves to ENTER_B with slot 4.
  - Slot 7 + enterpulse moves to START.
- START: lasts exactly one cycle. mult_start = 1, datainput_i = SLOT_NONE. Always moves to WAIT and clears the timeout counter.
- WAIT: the counter increments every cycle.
  - mult_done moves to SHOW with disp_sel = 0.
  - If the counter reaches TIMEOUT_CYCLES−1 without mult_done, move to ERROR.
  - If mult_done and the timeout arrive in the same cycle, mult_done wins.
  - mult_done is sampled only in WAIT; a done pulse in any other state is ignored.
- SHOW: each enterpulse increments disp_sel. enterpulse at disp_sel = 3 moves to ENTER_A with slot 0.
- ERROR: enterpulse moves to ENTER_A with slot 0.
- clearpulse has priority over enterpulse and mult_done in every state. It forces ENTER_A, slot 0, disp_sel 0, and a cleared counter.
- enterpulse is ignored in START and WAIT (no buffering).
- datainput_i = SLOT_NONE in START, WAIT, SHOW and ERROR.

## Timing
- Reset values: state ENTER_A, datainput_i = 0, mult_start = 0, busy = 0, result_valid = 0, error = 0, disp_sel = 0, counter = 0.
- Reset asserted mid-operation aborts immediately and asynchronously; mult_start drops at once.
- Slot update: enterpulse at edge n gives the new datainput_i after edge n. Capture uses the old value at edge n.
- Eighth enterpulse at edge n:
  - START is visible after edge n, with mult_start high for exactly one cycle.
  - WAIT begins after edge n+1.
- Latency from mult_done (sampled at edge m) to result_valid = 1 is one cycle (visible after edge m).
- Timeout: with no mult_done, ERROR is entered TIMEOUT_CYCLES cycles after WAIT entry.
- mult_start is never high for two consecutive cycles.
- busy and result_valid are never high together.

## Structure
- Shared package peripheral_mult_pkg holds:
  - typedef enum logic [2:0] seq_state_t.
  - Slot constants SLOT_A0 = 0, SLOT_B0 = 4, SLOT_LAST = 7, SLOT_NONE = 8.
  - The disp_sel encoding.
  - The capture block and the display mux import the same package.
- One sub-module: peripheral_timeout_counter (parameterised width from TIMEOUT_CYCLES; inputs clr and en; output expired).
- The FSM stays in the top module.

## Test plan
- Entry sweep: reset, then 8 enterpulses spaced 3 cycles apart.
  - datainput_i steps 0..7, then shows 8.
  - mult_start is high exactly once, one cycle after the 8th pulse.
  - busy is high from START onward.
- Completion and paging: mult_done 5 cycles after mult_start.
  - result_valid rises the next cycle.
  - 4 enterpulses step disp_sel 0, 1, 2, 3, then the block returns to ENTER_A with datainput_i = 0 and result_valid = 0.
- Timeout: TIMEOUT_CYCLES = 8 and mult_done never arrives.
  - error = 1 exactly 8 cycles after WAIT entry.
  - The next enterpulse gives error = 0 and datainput_i = 0.
- Simultaneous events:
  - clearpulse with enterpulse at slot 5 gives datainput_i = 0.
  - mult_done on the timeout cycle gives SHOW, not ERROR.
  - enterpulse during WAIT leaves state unchanged.
- Async reset mid-WAIT: assert reset between clock edges.
  - All outputs reach reset values without a clock edge.
  - After release the block accepts a full new entry sequence.
- Stray done: mult_done pulsed during ENTER_B (slot 6) does not change state or any output.
